// File: rtl/capture_engine_n_pkg.sv
// Shared types and sizing helpers for the capture/dump engine.
// Imported by the engine top and its decimator.
package capture_engine_n_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WAIT_TRIG,
    ST_POST,
    ST_DONE,
    ST_RD,
    ST_HOLD
  } cap_state_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // A single channel still needs a one-bit select port.
  function automatic int ch_w_of(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/capture_engine_n_if.sv
// Byte stream from the capture engine dump port to the command logic.
// Valid/ready handshake; a byte moves when both are high at a clock edge.
interface capture_engine_n_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] dump_data;
  logic              dump_vld;
  logic              dump_rdy;

  modport master (output dump_data, output dump_vld, input dump_rdy);
  modport slave  (input dump_data, input dump_vld, output dump_rdy);

endinterface

// File: rtl/capture_engine_n_sample_decimator.sv
// Sample-rate divider: one tick every 2**decimator clocks.
// The exponent is latched and the phase cleared on reload.
module sample_decimator #(
  parameter  int DEC_W = 4,
  localparam int CNT_W = (1 << DEC_W) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reload_i,
  input  logic [DEC_W-1:0] decimator_i,
  output logic             tick_o
);

  logic [DEC_W-1:0] dec_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] mask;

  // A zero exponent gives an all-zero mask, so every clock is a tick.
  assign mask   = ~({CNT_W{1'b1}} << dec_q);
  assign tick_o = (cnt_q == mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q <= '0;
      cnt_q <= '0;
    end else if (reload_i) begin
      dec_q <= decimator_i;
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/capture_engine_n.sv
// Multi-channel circular capture with post-trigger count, followed by an
// oldest-first per-channel dump over a valid/ready byte stream.
module capture_engine_n
  import capture_engine_n_pkg::*;
#(
  parameter  int NUM_CH = 3,
  parameter  int ADDR_W = 9,
  parameter  int DATA_W = 8,
  parameter  int DEC_W  = 4,
  localparam int CH_W   = ch_w_of(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     capture_en_i,
  input  logic                     abort_i,
  input  logic                     trigger_i,
  input  logic [DEC_W-1:0]         decimator_i,
  input  logic [ADDR_W-1:0]        trig_pos_i,
  output logic                     armed_o,
  output logic                     capture_done_o,
  output logic                     en_o,
  output logic                     we_o,
  output logic [ADDR_W-1:0]        addr_o,
  input  logic [NUM_CH*DATA_W-1:0] rdata_i,
  input  logic                     start_dump_i,
  input  logic [CH_W-1:0]          dump_ch_i,
  output logic                     dump_done_o,
  output logic                     dump_err_o,
  capture_engine_n_if.master       dump_if
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam int CNT_W = ADDR_W + 1;

  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W-1:0] tp_q, tp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              fresh_q, fresh_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              tick;
  logic              reload;
  logic              writing;
  logic [CNT_W-1:0]  fill_target;
  logic [CNT_W-1:0]  post_last;
  logic [DATA_W-1:0] rd_slice;

  // cnt_q is shared: fill count, post-trigger count, then dumped-byte count.
  assign fill_target = CNT_W'(DEPTH) - {1'b0, tp_q};
  assign post_last   = {1'b0, tp_q} - CNT_W'(1);
  assign rd_slice    = rdata_i[int'(ch_q)*DATA_W +: DATA_W];
  assign writing     = state_q inside {ST_FILL, ST_WAIT_TRIG, ST_POST};

  sample_decimator #(.DEC_W(DEC_W)) u_decimator (
    .clk         (clk),
    .rst_n       (rst_n),
    .reload_i    (reload),
    .decimator_i (decimator_i),
    .tick_o      (tick)
  );

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    tp_d    = tp_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    data_d  = data_q;
    fresh_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    reload  = 1'b0;
    en_o    = 1'b0;
    we_o    = 1'b0;
    addr_o  = '0;

    if (writing && tick) begin
      en_o   = 1'b1;
      we_o   = 1'b1;
      addr_o = wptr_q;
      wptr_d = wptr_q + ADDR_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (capture_en_i) reload = 1'b1;
      end
      ST_FILL: begin
        if (tick) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == fill_target) state_d = ST_WAIT_TRIG;
        end
      end
      ST_WAIT_TRIG: begin
        if (trigger_i) begin
          cnt_d   = '0;
          state_d = (tp_q == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (tick) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == post_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (capture_en_i) begin
          reload = 1'b1;
        end else if (start_dump_i) begin
          if ({1'b0, dump_ch_i} < (CH_W+1)'(NUM_CH)) begin
            state_d = ST_RD;
            rptr_d  = wptr_q;
            cnt_d   = '0;
            ch_d    = dump_ch_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RD: begin
        en_o    = 1'b1;
        addr_o  = rptr_q;
        fresh_d = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // RAM data is only live in the first HOLD cycle; keep a copy for stalls.
        if (fresh_q) data_d = rd_slice;
        if (dump_if.dump_rdy) begin
          rptr_d = rptr_q + ADDR_W'(1);
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DEPTH - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (reload) begin
      state_d = ST_FILL;
      wptr_d  = '0;
      cnt_d   = '0;
      tp_d    = trig_pos_i;
    end

    if (abort_i) begin
      state_d = ST_IDLE;
      reload  = 1'b0;
      fresh_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      tp_q    <= '0;
      cnt_q   <= '0;
      ch_q    <= '0;
      data_q  <= '0;
      fresh_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      tp_q    <= tp_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      fresh_q <= fresh_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign armed_o           = state_q inside {ST_WAIT_TRIG, ST_POST};
  assign capture_done_o    = state_q inside {ST_DONE, ST_RD, ST_HOLD};
  assign dump_if.dump_vld  = (state_q == ST_HOLD);
  assign dump_if.dump_data = (state_q == ST_HOLD) ? (fresh_q ? rd_slice : data_q) : '0;
  assign dump_done_o       = done_q;
  assign dump_err_o        = err_q;

endmodule

// File: tb/tb_capture_engine_n.sv
// Bench for capture_engine_n: RAM + ADC model, table of capture scenarios,
// and hand sequences for dump error, abort and asynchronous reset.
module tb_capture_engine_n;

  localparam int NUM_CH = 3;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int DEC_W  = 4;
  localparam int CH_W   = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LIMIT  = 20000;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     capture_en = 1'b0;
  logic                     abort = 1'b0;
  logic                     trigger = 1'b0;
  logic                     start_dump = 1'b0;
  logic [DEC_W-1:0]         decimator = '0;
  logic [ADDR_W-1:0]        trig_pos = '0;
  logic [CH_W-1:0]          dump_ch = '0;
  logic                     armed, capture_done, en, we, dump_done, dump_err;
  logic [ADDR_W-1:0]        addr;
  logic [NUM_CH*DATA_W-1:0] rdata;

  capture_engine_n_if #(.DATA_W(DATA_W)) dumpIf ();

  capture_engine_n #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEC_W(DEC_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .capture_en_i   (capture_en),
    .abort_i        (abort),
    .trigger_i      (trigger),
    .decimator_i    (decimator),
    .trig_pos_i     (trig_pos),
    .armed_o        (armed),
    .capture_done_o (capture_done),
    .en_o           (en),
    .we_o           (we),
    .addr_o         (addr),
    .rdata_i        (rdata),
    .start_dump_i   (start_dump),
    .dump_ch_i      (dump_ch),
    .dump_done_o    (dump_done),
    .dump_err_o     (dump_err),
    .dump_if        (dumpIf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // RAM + ADC environment: sample value is a function of channel and write index.
  logic              monClear = 1'b0;
  int                expGap = 1;
  int                wrCount = 0;
  int                gapErrs = 0;
  longint            cycleCount = 0;
  longint            lastWrCycle = -1;
  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];

  function automatic logic [DATA_W-1:0] adcSample(input int ch, input int idx);
    return DATA_W'(idx * 3 + (idx >>> 8) + ch * 85);
  endfunction

  always @(posedge clk) begin
    cycleCount <= cycleCount + 1;
    if (monClear) begin
      wrCount     <= 0;
      gapErrs     <= 0;
      lastWrCycle <= -1;
    end else if (en && we) begin
      for (int c = 0; c < NUM_CH; c++) mem[c][addr] <= adcSample(c, wrCount);
      wrCount <= wrCount + 1;
      if (lastWrCycle >= 0 && (cycleCount - lastWrCycle) != longint'(expGap))
        gapErrs <= gapErrs + 1;
      lastWrCycle <= cycleCount;
    end
    if (en) begin
      for (int c = 0; c < NUM_CH; c++) rdata[c*DATA_W +: DATA_W] <= mem[c][addr];
    end
  end

  typedef struct {
    int dec;
    int trigPos;
    int trigInFill;
    int trigAt;
    int dumpCh;
    int stall;
    int expArmed;
    int expTotal;
    int expGap;
  } vec_t;

  vec_t vecs [3];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic startCapture(input int dec, input int tp, input int gap);
    @(negedge clk);
    decimator  = DEC_W'(dec);
    trig_pos   = ADDR_W'(tp);
    expGap     = gap;
    capture_en = 1'b1;
    monClear   = 1'b1;
    @(negedge clk);
    capture_en = 1'b0;
    monClear   = 1'b0;
  endtask

  task automatic waitArmedThenTrigger(input int trigAt);
    for (int n = 0; n < LIMIT && !armed; n++) @(negedge clk);
    checkOutput("armedTimeout", armed, 1);
    for (int n = 0; n < LIMIT && wrCount < trigAt; n++) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic waitCaptureDone();
    for (int n = 0; n < LIMIT && !capture_done; n++) @(negedge clk);
    checkOutput("doneTimeout", capture_done, 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    startCapture(v.dec, v.trigPos, v.expGap);
    if (v.trigInFill != 0) begin
      repeat (20) @(negedge clk);
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      checkOutput("armedDuringFill", armed, 0);
    end
    for (int n = 0; n < LIMIT && !armed; n++) @(negedge clk);
    checkOutput("armedAtWrites", wrCount, v.expArmed);
    for (int n = 0; n < LIMIT && wrCount < v.trigAt; n++) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    checkOutput("doneRightAfterTrig", capture_done, v.trigPos == 0);
    waitCaptureDone();
    checkOutput("totalWrites", wrCount, v.expTotal);
    checkOutput("armedAtDone", armed, 0);
    checkOutput("writeSpacing", gapErrs, 0);
  endtask

  task automatic doDump(input int ch, input int stall, input int total);
    int k = 0, stallCnt = 0, byteErrs = 0, stableErrs = 0, doneSeen = 0;
    int firstBad = -1;
    logic [DATA_W-1:0] held = '0;
    logic [DATA_W-1:0] expByte;
    @(negedge clk);
    start_dump = 1'b1;
    dump_ch    = CH_W'(ch);
    @(negedge clk);
    start_dump = 1'b0;
    for (int n = 0; n < LIMIT && k < DEPTH; n++) begin
      if (dump_done) doneSeen++;
      if (dumpIf.dump_vld) begin
        if (stall > 0 && stallCnt > 0 && dumpIf.dump_data !== held) stableErrs++;
        if (stallCnt < stall) begin
          held            = dumpIf.dump_data;
          dumpIf.dump_rdy = 1'b0;
          stallCnt++;
        end else begin
          expByte = adcSample(ch, total - DEPTH + k);
          if (dumpIf.dump_data !== expByte) begin
            byteErrs++;
            if (firstBad < 0) firstBad = k;
          end
          dumpIf.dump_rdy = 1'b1;
          stallCnt        = 0;
          k++;
        end
      end else begin
        dumpIf.dump_rdy = 1'b0;
      end
      @(negedge clk);
    end
    dumpIf.dump_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (dump_done) doneSeen++;
      @(negedge clk);
    end
    if (byteErrs != 0) $display("[TB] first bad byte index %0d on ch%0d", firstBad, ch);
    checkOutput("dumpBytes", k, DEPTH);
    checkOutput("dumpDataErrs", byteErrs, 0);
    checkOutput("dumpStableErrs", stableErrs, 0);
    checkOutput("dumpDonePulses", doneSeen, 1);
    checkOutput("doneAfterDump", capture_done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // dec, trigPos, trigInFill, trigAt, dumpCh, stall, expArmed, expTotal, expGap
    vecs[0] = '{0, 100, 0, 599, 0, 0, 412, 700, 1};
    vecs[1] = '{3, 200, 1, 400, 1, 0, 312, 600, 8};
    vecs[2] = '{0,   0, 0, 520, 2, 5, 512, 521, 1};

    dumpIf.dump_rdy = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstArmed", armed, 0);
    checkOutput("rstCaptureDone", capture_done, 0);
    checkOutput("rstEn", en, 0);
    checkOutput("rstWe", we, 0);
    checkOutput("rstAddr", addr, 0);
    checkOutput("rstDumpVld", dumpIf.dump_vld, 0);
    checkOutput("rstDumpData", dumpIf.dump_data, 0);
    checkOutput("rstDumpDone", dump_done, 0);
    checkOutput("rstDumpErr", dump_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idleEn", en, 0);
    checkOutput("idleArmed", armed, 0);

    for (int i = 0; i < 3; i++) begin
      $display("[TB] scenario %0d: dec=%0d trig_pos=%0d", i, vecs[i].dec, vecs[i].trigPos);
      applyStimulus(vecs[i]);
      doDump(vecs[i].dumpCh, vecs[i].stall, vecs[i].expTotal);
    end

    // Out-of-range channel is rejected, then a valid channel still dumps.
    @(negedge clk);
    start_dump = 1'b1;
    dump_ch    = CH_W'(3);
    @(negedge clk);
    start_dump = 1'b0;
    checkOutput("dumpErrPulse", dump_err, 1);
    checkOutput("dumpErrStaysDone", capture_done, 1);
    @(negedge clk);
    checkOutput("dumpErrOneCycle", dump_err, 0);
    checkOutput("dumpErrNoRead", en, 0);
    doDump(1, 0, vecs[2].expTotal);

    // Abort while in POST.
    startCapture(0, 100, 1);
    waitArmedThenTrigger(450);
    repeat (10) @(negedge clk);
    checkOutput("armedInPost", armed, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abortPostArmed", armed, 0);
    checkOutput("abortPostDone", capture_done, 0);
    checkOutput("abortPostEn", en, 0);
    repeat (20) @(negedge clk);
    checkOutput("abortPostIdle", capture_done, 0);

    // Abort while a dump byte is held.
    startCapture(0, 0, 1);
    waitArmedThenTrigger(515);
    waitCaptureDone();
    start_dump = 1'b1;
    dump_ch    = CH_W'(0);
    @(negedge clk);
    start_dump = 1'b0;
    for (int n = 0; n < 20 && !dumpIf.dump_vld; n++) @(negedge clk);
    checkOutput("vldBeforeAbort", dumpIf.dump_vld, 1);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abortHoldVld", dumpIf.dump_vld, 0);
    checkOutput("abortHoldDone", capture_done, 0);
    checkOutput("abortHoldArmed", armed, 0);
    start_dump = 1'b1;
    @(negedge clk);
    start_dump = 1'b0;
    checkOutput("idleDumpErr", dump_err, 0);
    checkOutput("idleDumpNoRead", en, 0);
    @(negedge clk);
    checkOutput("idleDumpNoVld", dumpIf.dump_vld, 0);

    // Asynchronous reset in the middle of FILL.
    startCapture(0, 50, 1);
    repeat (30) @(negedge clk);
    checkOutput("fillWriting", en, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncRstEn", en, 0);
    checkOutput("asyncRstWe", we, 0);
    checkOutput("asyncRstAddr", addr, 0);
    checkOutput("asyncRstArmed", armed, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstDone", capture_done, 0);
    checkOutput("postRstEn", en, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
